// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the instruction-memory address
// and registers {pc+step, inst, valid} into the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] PC_STEP    = 32'd4,
  parameter logic [31:0] IMEM_LIMIT = 32'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_adrs,
  input  logic        flush,
  output logic [31:0] imem_adrs,
  input  logic [31:0] imem_inst,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out,
  output logic        halted
);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic [31:0] pc_nxt;
  logic        pc_oor;

  assign tgt       = {branch_adrs[31:2], 2'b00};
  assign pc_nxt    = pc + PC_STEP;
  assign pc_oor    = (pc > IMEM_LIMIT);
  assign imem_adrs = pc;

  // Invalid entries always carry a zero (NOP) instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      pc_out    <= '0;
      inst_out  <= '0;
      valid_out <= 1'b0;
      halted    <= 1'b0;
      state     <= RUN;
    end else if (branch_taken) begin
      pc        <= tgt;
      pc_out    <= '0;
      inst_out  <= '0;
      valid_out <= 1'b0;
      if (tgt > IMEM_LIMIT) begin
        state  <= HALT;
        halted <= 1'b1;
      end else begin
        state  <= RUN;
        halted <= 1'b0;
      end
    end else if (freeze) begin
      pc <= pc;
    end else if (state == RUN) begin
      if (pc_oor) begin
        state     <= HALT;
        halted    <= 1'b1;
        pc_out    <= '0;
        inst_out  <= '0;
        valid_out <= 1'b0;
      end else begin
        pc <= pc_nxt;
        if (flush) begin
          pc_out    <= '0;
          inst_out  <= '0;
          valid_out <= 1'b0;
        end else begin
          pc_out    <= pc_nxt;
          inst_out  <= imem_inst;
          valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction
// memory model: fixed words at 0/4/8, address-tagged words elsewhere.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_adrs;
  logic        flush;
  logic [31:0] imem_adrs;
  logic [31:0] imem_inst;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;
  logic        halted;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_adrs  (branch_adrs),
    .flush        (flush),
    .imem_adrs    (imem_adrs),
    .imem_inst    (imem_inst),
    .pc_out       (pc_out),
    .inst_out     (inst_out),
    .valid_out    (valid_out),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h8001060A;
      32'd4:   return 32'h04011000;
      32'd8:   return 32'h0C011800;
      default: return 32'hA0000000 | a;
    endcase
  endfunction

  always_comb imem_inst = mem(imem_adrs);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_adrs = '0;
    flush = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({pc_out, inst_out, valid_out, halted, imem_adrs}
        !== {32'd0, 32'd0, 1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL reset: got pc_out=%h inst=%h v=%b h=%b adrs=%h",
               pc_out, inst_out, valid_out, halted, imem_adrs);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] epc [3];
    logic [31:0] ein [3];
    epc = '{32'd4, 32'd8, 32'd12};
    ein = '{32'h8001060A, 32'h04011000, 32'h0C011800};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({pc_out, inst_out, valid_out, imem_adrs}
          !== {epc[i], ein[i], 1'b1, epc[i]}) begin
        bad++;
        $display("FAIL seq%0d: got %h %h %b adrs=%h want %h %h 1 adrs=%h",
                 i, pc_out, inst_out, valid_out, imem_adrs,
                 epc[i], ein[i], epc[i]);
      end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    step();
    step();
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      flush = (i == 1);
      step();
      total++;
      if ({pc_out, inst_out, valid_out, imem_adrs}
          !== {32'd8, 32'h04011000, 1'b1, 32'd8}) begin
        bad++;
        $display("FAIL freeze%0d: got %h %h %b adrs=%h want 8 04011000 1 adrs=8",
                 i, pc_out, inst_out, valid_out, imem_adrs);
      end
    end
    freeze = 1'b0;
    flush = 1'b0;
    step();
    total++;
    if ({pc_out, inst_out, valid_out, imem_adrs}
        !== {32'd12, 32'h0C011800, 1'b1, 32'd12}) begin
      bad++;
      $display("FAIL unfreeze: got %h %h %b adrs=%h want c 0c011800 1 adrs=c",
               pc_out, inst_out, valid_out, imem_adrs);
    end
  endtask

  task automatic test_branch_freeze();
    branch_adrs = 32'h13;
    branch_taken = 1'b1;
    freeze = 1'b1;
    step();
    branch_taken = 1'b0;
    freeze = 1'b0;
    total++;
    if ({pc_out, inst_out, valid_out, imem_adrs, halted}
        !== {32'd0, 32'd0, 1'b0, 32'h10, 1'b0}) begin
      bad++;
      $display("FAIL branch: got %h %h %b adrs=%h h=%b want 0 0 0 adrs=10 h=0",
               pc_out, inst_out, valid_out, imem_adrs, halted);
    end
    step();
    total++;
    if ({pc_out, inst_out, valid_out, imem_adrs}
        !== {32'h14, 32'hA0000010, 1'b1, 32'h14}) begin
      bad++;
      $display("FAIL branch_next: got %h %h %b adrs=%h want 14 a0000010 1 adrs=14",
               pc_out, inst_out, valid_out, imem_adrs);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if ({pc_out, inst_out, valid_out, imem_adrs}
        !== {32'd0, 32'd0, 1'b0, 32'd8}) begin
      bad++;
      $display("FAIL flush: got %h %h %b adrs=%h want 0 0 0 adrs=8",
               pc_out, inst_out, valid_out, imem_adrs);
    end
    step();
    total++;
    if ({pc_out, inst_out, valid_out}
        !== {32'd12, 32'h0C011800, 1'b1}) begin
      bad++;
      $display("FAIL post_flush: got %h %h %b want c 0c011800 1",
               pc_out, inst_out, valid_out);
    end
  endtask

  task automatic test_halt();
    branch_adrs = 32'd96;
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    step();
    step();
    total++;
    if ({pc_out, inst_out, valid_out, imem_adrs, halted}
        !== {32'd104, 32'hA0000064, 1'b1, 32'd104, 1'b0}) begin
      bad++;
      $display("FAIL last_fetch: got %h %h %b adrs=%h h=%b want 68 a0000064 1 adrs=68 h=0",
               pc_out, inst_out, valid_out, imem_adrs, halted);
    end
    step();
    total++;
    if ({valid_out, inst_out, halted, imem_adrs}
        !== {1'b0, 32'd0, 1'b1, 32'd104}) begin
      bad++;
      $display("FAIL halt: got v=%b inst=%h h=%b adrs=%h want v=0 inst=0 h=1 adrs=68",
               valid_out, inst_out, halted, imem_adrs);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({valid_out, halted, imem_adrs} !== {1'b0, 1'b1, 32'd104}) begin
        bad++;
        $display("FAIL halt_hold%0d: got v=%b h=%b adrs=%h want v=0 h=1 adrs=68",
                 i, valid_out, halted, imem_adrs);
      end
    end
    branch_adrs = 32'd0;
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    total++;
    if ({halted, imem_adrs, valid_out} !== {1'b0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL unhalt: got h=%b adrs=%h v=%b want h=0 adrs=0 v=0",
               halted, imem_adrs, valid_out);
    end
    branch_adrs = 32'h201;
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    total++;
    if ({halted, imem_adrs, valid_out} !== {1'b1, 32'h200, 1'b0}) begin
      bad++;
      $display("FAIL branch_oor: got h=%b adrs=%h v=%b want h=1 adrs=200 v=0",
               halted, imem_adrs, valid_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({pc_out, inst_out, valid_out, halted, imem_adrs}
        !== {32'd0, 32'd0, 1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL async_rst: got %h %h %b h=%b adrs=%h want all zero",
               pc_out, inst_out, valid_out, halted, imem_adrs);
    end
    rst = 1'b0;
    step();
    total++;
    if ({pc_out, inst_out, valid_out, imem_adrs}
        !== {32'd4, 32'h8001060A, 1'b1, 32'd4}) begin
      bad++;
      $display("FAIL after_rst: got %h %h %b adrs=%h want 4 8001060a 1 adrs=4",
               pc_out, inst_out, valid_out, imem_adrs);
    end
  endtask

  initial begin
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_adrs = '0;
    flush = 1'b0;
    test_reset();
    test_sequential();
    test_freeze();
    test_branch_freeze();
    test_flush();
    test_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
